// File: rtl/mem_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mem_arb_pkg
// Purpose : Types and constants shared by the memory arbiter and its
//           round-robin picker.
// Contents:
//   arb_state_e - arbiter FSM state encoding (IDLE, ISSUE, WAIT)
//   MEM_DEPTH   - number of words in the shared memory
//   DEF_ADDR_W  - default memory address width
//   DEF_DATA_W  - default memory data width
//   idx_w()     - width of a requester index for a given requester count
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int MEM_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  // Index width for N requesters. Never returns 0 so that a degenerate
  // single-requester build still has a legal vector width.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rr_picker
// Purpose : Combinational round-robin selector. Returns the first asserted
//           request at or above the pointer, wrapping from N_REQ-1 to 0.
// Ports:
//   i_req   [N_REQ-1:0] - request vector
//   i_ptr   [IDX_W-1:0] - starting search position (must be < N_REQ)
//   o_grant [N_REQ-1:0] - one-hot grant (all zero when no request)
//   o_idx   [IDX_W-1:0] - binary index of the granted requester
//   o_any               - at least one request present
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_cand;

  // Walk N_REQ positions starting at the pointer; the first hit wins and
  // o_any then masks every later candidate.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % N_REQ;
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = IDX_W'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mem_arbiter
// Purpose : Round-robin arbiter giving N_REQ requesters shared access to a
//           single-port memory. One request is accepted per transaction via
//           valid/ready, the memory is driven for one cycle, read data is
//           collected a cycle later, and a one-hot completion pulse is
//           returned to the granted requester.
// Optional: define MEM_ARB_LOCK_EN to add the req_lock input, which lets a
//           requester keep priority across consecutive transactions.
// Ports:
//   CLK, RST (async, active-low)
//   req_valid/req_wr [N_REQ]          - per-requester request and direction
//   req_addr  [N_REQ*ADDR_W]          - packed addresses, slot i at i*ADDR_W
//   req_wdata [N_REQ*DATA_W]          - packed write data
//   req_lock  [N_REQ]                 - (MEM_ARB_LOCK_EN only) hold priority
//   req_ready [N_REQ]                 - one-hot accept, IDLE only
//   rsp_valid [N_REQ], rsp_rdata, rsp_err - completion pulse and payload
//   mem_en, mem_wr, mem_addr, mem_wdata   - memory command (ISSUE only)
//   mem_rdata, mem_rvalid                 - memory read return
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_lock,
`endif
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_en,
  output logic                    mem_wr,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_rvalid
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_e r_state;
  arb_state_e w_next;

  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_gidx;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [IDX_W-1:0]  w_eff_ptr;
  logic [IDX_W-1:0]  w_ptr_next;
  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_any;
  logic              w_accept;
  logic [N_REQ-1:0]  w_rsp_oh;

  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  //--------------------------------------------------------------------------
  // Pointer selection. While a lock is held the pointer sits on the locked
  // requester, so it wins automatically as long as it keeps requesting. The
  // first IDLE where it stops requesting advances the search past it.
  //--------------------------------------------------------------------------
`ifdef MEM_ARB_LOCK_EN
  logic r_locked;

  always_comb begin
    w_eff_ptr  = (r_locked && !req_valid[r_rr_ptr]) ? f_inc(r_rr_ptr) : r_rr_ptr;
    w_ptr_next = req_lock[w_gidx] ? w_gidx : f_inc(w_gidx);
  end
`else
  always_comb begin
    w_eff_ptr  = r_rr_ptr;
    w_ptr_next = f_inc(w_gidx);
  end
`endif

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (w_eff_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_rsp_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_gidx;

  //--------------------------------------------------------------------------
  // FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready = w_grant;
          w_accept  = 1'b1;
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_wr    = r_wr;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        w_next    = r_wr ? IDLE : WAIT;
      end
      WAIT: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Request latch, round-robin pointer and response registers
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rr_ptr    <= '0;
      r_gidx      <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;

      if (w_accept) begin
        r_gidx   <= w_gidx;
        r_wr     <= req_wr[w_gidx];
        r_addr   <= req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
        r_wdata  <= req_wdata[int'(w_gidx)*DATA_W +: DATA_W];
        r_rr_ptr <= w_ptr_next;
      end else if (r_state == IDLE) begin
        // Only differs from r_rr_ptr when a lock is being released with no
        // other request present.
        r_rr_ptr <= w_eff_ptr;
      end

      if (r_state == ISSUE && r_wr) begin
        r_rsp_valid <= w_rsp_oh;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end

      if (r_state == WAIT) begin
        r_rsp_valid <= w_rsp_oh;
        r_rsp_rdata <= mem_rdata;
        r_rsp_err   <= !mem_rvalid;
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_locked <= 1'b0;
    end else if (w_accept) begin
      r_locked <= req_lock[w_gidx];
    end else if (r_state == IDLE && r_locked && !req_valid[r_rr_ptr]) begin
      r_locked <= 1'b0;
    end
  end
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_mem_arbiter
// Purpose : Directed self-checking bench for mem_arbiter with a behavioural
//           16 x 32 memory model (registered read, cleared on reset).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_wr    = '0;
  logic [15:0]  req_addr  = '0;
  logic [127:0] req_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
  logic [3:0]   req_lock  = '0;
`endif
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         mem_en;
  logic         mem_wr;
  logic [3:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;

  logic [31:0]  mem [16];
  logic         mem_rvalid_raw;
  logic         kill_rvalid = 1'b0;

  int cyc = 0;
  int pass_cnt = 0;
  int tot_cnt = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mem_arbiter #(.N_REQ(4), .ADDR_W(4), .DATA_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef MEM_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  // Memory model: acts on the edge closing the enable cycle.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem_rdata      <= '0;
      mem_rvalid_raw <= 1'b0;
    end else begin
      mem_rvalid_raw <= 1'b0;
      if (mem_en) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        else begin
          mem_rdata      <= mem[mem_addr];
          mem_rvalid_raw <= 1'b1;
        end
      end
    end
  end
  assign mem_rvalid = mem_rvalid_raw & ~kill_rvalid;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    req_valid = '0;
    RST = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    tick();
  endtask

  // Drive one request from requester idx, return accept cycle, response
  // cycle (-1 on timeout) and response payload.
  task automatic issue(input int idx, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, output int acc, output int rsp,
                       output logic [3:0] rv, output logic [31:0] rd,
                       output logic er);
    req_valid = '0;
    req_wr[idx] = wr;
    req_addr[idx*4 +: 4] = a;
    req_wdata[idx*32 +: 32] = d;
    req_valid[idx] = 1'b1;
    #1;
    acc = -1; rsp = -1; rv = '0; rd = '0; er = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready[idx]) begin acc = cyc; break; end
      tick();
    end
    tick();
    req_valid[idx] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (|rsp_valid) begin
        rsp = cyc; rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int acc, rsp; logic [3:0] rv; logic [31:0] rd; logic er;
    #1;
    tot_cnt++;
    if ({req_ready, rsp_valid, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      $display("FAIL reset_during: outputs=%h required 0",
               {req_ready, rsp_valid, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata, rsp_rdata});
    end else pass_cnt++;
    RST = 1'b1;
    tick();
    tot_cnt++;
    if ({req_ready, rsp_valid, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      $display("FAIL reset_after: outputs=%h required 0",
               {req_ready, rsp_valid, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata, rsp_rdata});
    end else pass_cnt++;
    issue(0, 1'b0, 4'd5, 32'h0, acc, rsp, rv, rd, er);
    tot_cnt++;
    if (acc < 0 || rsp - acc !== 3) $display("FAIL reset_read_latency: got %0d required 3", rsp - acc);
    else pass_cnt++;
    tot_cnt++;
    if ({rv, rd, er} !== {4'b0001, 32'h0, 1'b0})
      $display("FAIL reset_read_rsp: rv=%b rd=%h err=%b required 0001/0/0", rv, rd, er);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    int acc, rsp; logic [3:0] rv; logic [31:0] rd; logic er;
    issue(0, 1'b1, 4'd3, 32'hDEADBEEF, acc, rsp, rv, rd, er);
    tot_cnt++;
    if (acc < 0 || rsp - acc !== 2) $display("FAIL write_latency: got %0d required 2", rsp - acc);
    else pass_cnt++;
    tot_cnt++;
    if ({rv, rd} !== {4'b0001, 32'h0}) $display("FAIL write_rsp: rv=%b rd=%h required 0001/0", rv, rd);
    else pass_cnt++;
    issue(0, 1'b0, 4'd3, 32'h0, acc, rsp, rv, rd, er);
    tot_cnt++;
    if (acc < 0 || rsp - acc !== 3) $display("FAIL read_latency: got %0d required 3", rsp - acc);
    else pass_cnt++;
    tot_cnt++;
    if ({rv, rd, er} !== {4'b0001, 32'hDEADBEEF, 1'b0})
      $display("FAIL read_rsp: rv=%b rd=%h err=%b required 0001/deadbeef/0", rv, rd, er);
    else pass_cnt++;
  endtask

  task automatic test_mem_port();
    int acc, rsp; logic [3:0] rv; logic [31:0] rd; logic er;
    bit got;
    req_valid = '0;
    req_wr[2] = 1'b1; req_addr[8 +: 4] = 4'hA; req_wdata[64 +: 32] = 32'h12345678;
    req_valid[2] = 1'b1;
    #1;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (req_ready[2]) begin got = 1; break; end
      tick();
    end
    tot_cnt++;
    if (!got || req_ready !== 4'b0100) $display("FAIL port_ready: got %b required 0100", req_ready);
    else pass_cnt++;
    tick();
    tot_cnt++;
    if ({req_ready, mem_en, mem_wr, mem_addr, mem_wdata} !== {4'b0000, 1'b1, 1'b1, 4'hA, 32'h12345678})
      $display("FAIL port_issue: rdy=%b en=%b wr=%b a=%h d=%h required 0000/1/1/a/12345678",
               req_ready, mem_en, mem_wr, mem_addr, mem_wdata);
    else pass_cnt++;
    req_valid[2] = 1'b0;
    tick();
    tot_cnt++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, rsp_valid} !== {1'b0, 1'b0, 4'h0, 32'h0, 4'b0100})
      $display("FAIL port_after: en=%b wr=%b a=%h d=%h rv=%b required 0/0/0/0/0100",
               mem_en, mem_wr, mem_addr, mem_wdata, rsp_valid);
    else pass_cnt++;
    issue(3, 1'b0, 4'hA, 32'h0, acc, rsp, rv, rd, er);
    tot_cnt++;
    if ({rv, rd, er} !== {4'b1000, 32'h12345678, 1'b0})
      $display("FAIL port_readback: rv=%b rd=%h err=%b required 1000/12345678/0", rv, rd, er);
    else pass_cnt++;
  endtask

  task automatic test_rr_all();
    int g[$]; int gc[$];
    int exp_g[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_wr = '0;
    for (int i = 0; i < 4; i++) req_addr[i*4 +: 4] = 4'(i);
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) begin g.push_back(i); gc.push_back(cyc); end
      if (g.size() == 5) break;
      tick();
    end
    tick();
    req_valid = '0;
    repeat (4) tick();
    tot_cnt++;
    if (g.size() !== 5) $display("FAIL rr_count: got %0d grants required 5", g.size());
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tot_cnt++;
      if (g[k] !== exp_g[k]) $display("FAIL rr_order[%0d]: got %0d required %0d", k, g[k], exp_g[k]);
      else pass_cnt++;
    end
    for (int k = 0; k < 4; k++) begin
      tot_cnt++;
      if (gc[k+1] - gc[k] !== 3) $display("FAIL rr_gap[%0d]: got %0d required 3", k, gc[k+1] - gc[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_drop();
    int g[$];
    int exp_g[7] = '{0, 1, 2, 3, 0, 1, 3};
    bit drop2;
    do_reset();
    req_wr = '0;
    req_valid = 4'hF;
    drop2 = 0;
    #1;
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) begin g.push_back(i); if (i == 2) drop2 = 1; end
      if (g.size() == 7) break;
      tick();
      if (drop2) req_valid[2] = 1'b0;
    end
    tick();
    req_valid = '0;
    repeat (4) tick();
    tot_cnt++;
    if (g.size() !== 7) $display("FAIL drop_count: got %0d grants required 7", g.size());
    else pass_cnt++;
    for (int k = 0; k < 7; k++) begin
      tot_cnt++;
      if (g[k] !== exp_g[k]) $display("FAIL drop_order[%0d]: got %0d required %0d", k, g[k], exp_g[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rvalid_err();
    int acc, rsp; logic [3:0] rv; logic [31:0] rd; logic er;
    kill_rvalid = 1'b1;
    issue(1, 1'b0, 4'd3, 32'h0, acc, rsp, rv, rd, er);
    kill_rvalid = 1'b0;
    tot_cnt++;
    if ({rv, er} !== {4'b0010, 1'b1}) $display("FAIL err_set: rv=%b err=%b required 0010/1", rv, er);
    else pass_cnt++;
    tick();
    tot_cnt++;
    if (rsp_err !== 1'b1) $display("FAIL err_hold: got %b required 1", rsp_err);
    else pass_cnt++;
    issue(1, 1'b0, 4'd3, 32'h0, acc, rsp, rv, rd, er);
    tot_cnt++;
    if ({rv, er} !== {4'b0010, 1'b0}) $display("FAIL err_clear: rv=%b err=%b required 0010/0", rv, er);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acc, rsp; logic [3:0] rv; logic [31:0] rd; logic er;
    bit seen;
    do_reset();
    req_wr[0] = 1'b1; req_addr[0 +: 4] = 4'd7; req_wdata[0 +: 32] = 32'hCAFEF00D;
    req_valid = 4'b0001;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (req_ready[0]) break;
      tick();
    end
    tick();
    req_valid = '0;
    tot_cnt++;
    if (mem_en !== 1'b1) $display("FAIL abort_issue: mem_en=%b required 1", mem_en);
    else pass_cnt++;
    RST = 1'b0;
    #1;
    tot_cnt++;
    if ({mem_en, mem_addr} !== {1'b0, 4'h0}) $display("FAIL abort_reset: en=%b a=%h required 0/0", mem_en, mem_addr);
    else pass_cnt++;
    tick();
    RST = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (|rsp_valid) seen = 1;
      tick();
    end
    tot_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_no_rsp: rsp seen=%b required 0", seen);
    else pass_cnt++;
    issue(0, 1'b0, 4'd7, 32'h0, acc, rsp, rv, rd, er);
    tot_cnt++;
    if ({rv, rd, er} !== {4'b0001, 32'h0, 1'b0})
      $display("FAIL abort_readback: rv=%b rd=%h err=%b required 0001/0/0", rv, rd, er);
    else pass_cnt++;
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    int acc, rsp; logic [3:0] rv; logic [31:0] rd; logic er;
    int g[$]; int n1;
    int exp_g[4] = '{1, 1, 2, 0};
    do_reset();
    issue(0, 1'b1, 4'd0, 32'h1, acc, rsp, rv, rd, er);
    req_wr = '0;
    req_lock = 4'b0010;
    req_valid = 4'b0111;
    n1 = 0;
    #1;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) begin g.push_back(i); if (i == 1) n1++; end
      if (g.size() == 4) break;
      tick();
      if (n1 == 2) begin req_valid[1] = 1'b0; req_lock[1] = 1'b0; end
    end
    tick();
    req_valid = '0;
    req_lock = '0;
    repeat (4) tick();
    tot_cnt++;
    if (g.size() !== 4) $display("FAIL lock_count: got %0d grants required 4", g.size());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      tot_cnt++;
      if (g[k] !== exp_g[k]) $display("FAIL lock_order[%0d]: got %0d required %0d", k, g[k], exp_g[k]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_mem_port();
    test_rr_all();
    test_drop();
    test_rvalid_err();
    test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule
`default_nettype wire
